// File: rtl/lockin_pkg.sv
// Shared state encoding, limits and helpers for the lock-in acquisition sequencer.
package lockin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ACQUIRE = 3'd3,
        ST_DONE    = 3'd4
    } lockin_state_e;

    localparam int unsigned LUT_DEPTH_C = 2048;
    localparam int unsigned MIN_PTOS_C  = 2;

    function automatic logic is_pow2(input logic [15:0] x);
        return (x != 16'd0) && ((x & (x - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/lockin_cfg_check.sv
// Combinational check of points-per-cycle / cycle-count and the product-sample target.
module lockin_cfg_check
    import lockin_pkg::*;
#(
    parameter int unsigned LUT_DEPTH = LUT_DEPTH_C
) (
    input  logic [15:0] ptos_x_ciclo,
    input  logic [15:0] n_ciclos,
    output logic        valid,
    output logic [31:0] target
);

    // M must tile the reference LUT exactly, hence power of two within [MIN, LUT_DEPTH].
    always_comb begin
        valid  = is_pow2(ptos_x_ciclo)
              && (32'(ptos_x_ciclo) >= MIN_PTOS_C)
              && (32'(ptos_x_ciclo) <= LUT_DEPTH)
              && (n_ciclos != 16'd0);
        target = 32'(ptos_x_ciclo) * 32'(n_ciclos);
    end

endmodule

// File: rtl/lockin_acq_sequencer.sv
// Sequences multiplier reset, pipeline flush and accumulator gating for one
// lock-in acquisition of M x N product samples.
module lockin_acq_sequencer
    import lockin_pkg::*;
#(
    parameter int unsigned PIPE_LAT  = 4,
    parameter int unsigned LUT_DEPTH = LUT_DEPTH_C
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] ptos_x_ciclo,
    input  logic [15:0] n_ciclos,
    input  logic        mult_valid,
    output logic        mult_rst_n,
    output logic        mult_enable,
    output logic        acc_clear,
    output logic        acc_enable,
    output logic        busy,
    output logic        done,
    output logic        cfg_error,
    output logic [15:0] ptos_cfg,
    output logic [31:0] sample_cnt,
    output logic [2:0]  dbg_state
);

    // Handshake: mult_valid is a one-cycle strobe with no backpressure; a product is
    // accepted on the rising edge where acc_enable (mult_valid while ACQUIRE) is high.

    lockin_state_e state_q;
    logic          mult_rst_n_q, mult_enable_q, acc_clear_q, busy_q, done_q, cfg_error_q;
    logic          flush_q;
    logic [15:0]   ptos_cfg_q, settle_cnt_q, settle_cnt_d;
    logic [31:0]   target_q, sample_cnt_q, sample_cnt_d;
    logic          cfg_valid;
    logic [31:0]   cfg_target;

    lockin_cfg_check #(.LUT_DEPTH(LUT_DEPTH)) u_cfg_check (
        .ptos_x_ciclo (ptos_x_ciclo),
        .n_ciclos     (n_ciclos),
        .valid        (cfg_valid),
        .target       (cfg_target)
    );

    assign settle_cnt_d = settle_cnt_q + 16'd1;
    assign sample_cnt_d = sample_cnt_q + 32'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mult_rst_n_q  <= 1'b0;
            mult_enable_q <= 1'b0;
            acc_clear_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_error_q   <= 1'b0;
            flush_q       <= 1'b0;
            ptos_cfg_q    <= 16'd0;
            settle_cnt_q  <= 16'd0;
            target_q      <= 32'd0;
            sample_cnt_q  <= 32'd0;
        end else if (abort) begin
            state_q       <= ST_IDLE;
            mult_rst_n_q  <= 1'b1;
            mult_enable_q <= 1'b0;
            acc_clear_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mult_rst_n_q  <= 1'b1;
                    mult_enable_q <= 1'b0;
                    acc_clear_q   <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    if (start) begin
                        ptos_cfg_q <= ptos_x_ciclo;
                        target_q   <= cfg_target;
                        if (cfg_valid) begin
                            cfg_error_q  <= 1'b0;
                            state_q      <= ST_FLUSH;
                            mult_rst_n_q <= 1'b0;
                            acc_clear_q  <= 1'b1;
                            busy_q       <= 1'b1;
                            flush_q      <= 1'b0;
                            sample_cnt_q <= 32'd0;
                        end else begin
                            cfg_error_q <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    acc_clear_q <= 1'b0;
                    if (flush_q) begin
                        state_q       <= ST_SETTLE;
                        mult_rst_n_q  <= 1'b1;
                        mult_enable_q <= 1'b1;
                        settle_cnt_q  <= 16'd0;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Products still in flight from before the reset are dropped here.
                    if (mult_valid) begin
                        settle_cnt_q <= settle_cnt_d;
                        if (settle_cnt_d == 16'(PIPE_LAT)) state_q <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (mult_valid) begin
                        sample_cnt_q <= sample_cnt_d;
                        if (sample_cnt_d == target_q) begin
                            state_q       <= ST_DONE;
                            done_q        <= 1'b1;
                            mult_enable_q <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign acc_enable  = mult_valid && (state_q == ST_ACQUIRE);
    assign mult_rst_n  = mult_rst_n_q;
    assign mult_enable = mult_enable_q;
    assign acc_clear   = acc_clear_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_error   = cfg_error_q;
    assign ptos_cfg    = ptos_cfg_q;
    assign sample_cnt  = sample_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/lockin_acq_sequencer.md
# lockin_acq_sequencer

Acquisition sequencer for the lock-in reference-multiplication stage. It validates the points-per-cycle configuration and resets the multiplier so its reference index starts at phase 0. It then discards the samples still in the multiplier pipeline and gates the downstream accumulator for exactly `ptos_x_ciclo × n_ciclos` product samples before signalling completion. It sits between the HPS/Avalon control registers and the multiplier + accumulator datapath.

## Interface
Parameters:
- `PIPE_LAT`, default 4: number of leading `mult_valid` pulses to discard after the multiplier reset (pipeline fill).
- `LUT_DEPTH`, default 2048: reference LUT depth; `ptos_x_ciclo` must divide it exactly.

Ports (clock and reset first):
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin an acquisition; sampled only in IDLE.
- `abort`  in  1  level; forces a return to IDLE.
- `ptos_x_ciclo`  in  16  points per reference cycle (M).
- `n_ciclos`  in  16  number of reference cycles to integrate (N).
- `mult_valid`  in  1  multiplier output valid strobe.
- `mult_rst_n`  out  1  active-low reset to the multiplier.
- `mult_enable`  out  1  multiplier enable.
- `acc_clear`  out  1  one-cycle accumulator clear.
- `acc_enable`  out  1  accumulator sample-accept qualifier.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `cfg_error`  out  1  sticky configuration-error flag.
- `ptos_cfg`  out  16  latched M, drives the multiplier's `ptos_x_ciclo`.
- `sample_cnt`  out  32  number of products accepted so far.

## Operation
- States: IDLE, FLUSH, SETTLE, ACQUIRE, DONE.
- **IDLE.** `mult_rst_n`=1, `mult_enable`=0, `acc_enable`=0. On `start` the block latches M into `ptos_cfg`, latches N, and computes `target` = M×N as a 32-bit unsigned product.
  - Configuration is valid iff M is a power of two, 2 ≤ M ≤ `LUT_DEPTH`, and N ≠ 0.
  - Invalid configuration: set `cfg_error`, stay in IDLE.
  - Valid configuration: clear `cfg_error`, go to FLUSH.
- **FLUSH.** Exactly 2 cycles. `mult_rst_n`=0, which resets the reference index to phase 0. `acc_clear`=1 on the first FLUSH cycle only. `sample_cnt` is cleared. Then go to SETTLE.
- **SETTLE.** `mult_enable`=1. Count `mult_valid` pulses. After `PIPE_LAT` pulses have been seen, go to ACQUIRE on the following cycle.
- **ACQUIRE.** `mult_enable`=1.
  - `acc_enable` is combinational: `mult_valid` AND (state==ACQUIRE). The accumulator therefore accepts exactly `target` products.
  - `sample_cnt` increments on each accepted product.
  - When an accepted product makes `sample_cnt` == `target`, go to DONE.
- **DONE.** 1 cycle. `done`=1, `mult_enable`=0. Then go to IDLE. `sample_cnt` holds its final value until the next FLUSH.
- **abort.** Takes priority over every other transition. From any state the block goes to IDLE on the next edge: `done` is not pulsed, `mult_enable`/`acc_enable` drop, `cfg_error` is unchanged.
- `start` while busy is ignored. `start` and `abort` in the same IDLE cycle: abort wins and no acquisition starts.
- Widths: `sample_cnt` and `target` are 32-bit unsigned. The maximum target, 2048×65535, fits without wrap.

## Timing
- Reset values:
  - State: IDLE.
  - `mult_rst_n`=0 during reset, 1 from the first cycle after reset is released.
  - All other outputs 0; `ptos_cfg`=0.
- `start` sampled at edge T:
  - `busy`=1 from T+1.
  - `mult_rst_n` low for T+1 and T+2.
  - `acc_clear` high for T+1.
  - `mult_enable` high from T+3.
- `done` is high the cycle after the edge that accepts the last product. `busy` falls together with `done`.
- All outputs are registered except `acc_enable`, which has zero latency from `mult_valid`.
- Asynchronous reset mid-acquisition: all state is lost, `done` is not pulsed, and the multiplier is held in reset.

## Structure
- Package `lockin_pkg` holds:
  - the state enum;
  - `LUT_DEPTH_C`=2048;
  - `MIN_PTOS_C`=2;
  - the `is_pow2` function.
- One combinational sub-module, `lockin_cfg_check` (inputs M and N; outputs `valid` and `target`). Everything else is a single FSM with counters.

## Test plan
- M=64, N=3, continuous `mult_valid` → first 4 pulses ignored; exactly 192 `acc_enable` pulses; `done` one cycle after the 192nd; `sample_cnt`=192.
- M=100, N=5 → `cfg_error`=1, `busy` stays 0, `mult_enable` never asserts. A following `start` with M=32, N=1 clears `cfg_error` and completes after 32 accepted products.
- M=16, N=2, `mult_valid` every 3rd cycle → `acc_enable` coincides with `mult_valid` only; `done` follows the 32nd accepted product.
- `abort` asserted after 10 accepted products (M=8, N=4) → IDLE next cycle, no `done`, `sample_cnt`=10. A restart pulses `acc_clear` and resets the count to 0.
- `start` pulsed again during ACQUIRE → no effect; counting continues and `done` occurs once.
- `reset_n` deasserted during SETTLE → all outputs at reset values immediately (asynchronously), state IDLE after release.
